// File: rtl/sr_mul_pkg.sv
// Purpose : shared types and sizes for the sequential shift-add multiplier.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package sr_mul_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_BUSY,
      MUL_DONE
   } mul_state_t;

   localparam int MUL_W     = 32;
   // One extra bit so the iteration counter can hold the value MUL_W itself.
   localparam int MUL_CNT_W = $clog2(MUL_W) + 1;

endpackage

// File: rtl/sr_seq_mul_if.sv
// Purpose : CPU <-> multiplier handshake bundle (level start, one-cycle end_mul strobe).
// Latency : n/a (wires only).
// Backpressure: none; the initiator holds start and operands stable until end_mul.
// Ports   : a, b, start driven by the master (CPU); res_mul, end_mul, busy driven by the slave (multiplier).
interface sr_seq_mul_if
   import sr_mul_pkg::*;
#(
   parameter int W = MUL_W
);
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         start;
   logic [W-1:0] res_mul;
   logic         end_mul;
   logic         busy;

   modport master (output a, b, start, input res_mul, end_mul, busy);
   modport slave  (input a, b, start, output res_mul, end_mul, busy);
endinterface

// File: rtl/sr_seq_mul.sv
// Purpose : radix-2 shift-add multiplier returning the low W bits of a*b (RISC-V MUL).
// Latency : W+1 cycles from the start sample; with SR_MUL_EARLY_EXIT_EN, (msb index of b)+3, capped at W+1.
// Backpressure: none; dropping start while busy aborts, start is ignored in the DONE cycle.
// Ports   : clk, rst (sync, active high); mulIf.slave carries a, b, start in and res_mul, end_mul, busy out.
// Config  : define SR_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module sr_seq_mul
   import sr_mul_pkg::*;
#(
   parameter int W = MUL_W
)(
   input  logic         clk,
   input  logic         rst,
   sr_seq_mul_if.slave  mulIf
);

   localparam int CNT_W = $clog2(W) + 1;

   mul_state_t   state;
   logic [W-1:0] mcand;
   logic [W-1:0] mplier;
   logic [W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic         endMul;
   logic         busyQ;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= MUL_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         endMul <= 1'b0;
         busyQ  <= 1'b0;
      end else begin
         case (state)
            MUL_IDLE: begin
               endMul <= 1'b0;
               if (mulIf.start) begin
                  mcand  <= mulIf.a;
                  mplier <= mulIf.b;
                  acc    <= '0;
                  cnt    <= '0;
                  busyQ  <= 1'b1;
                  state  <= MUL_BUSY;
               end
            end

            MUL_BUSY: begin
               if (!mulIf.start) begin
                  // Abort: the instruction went away; keep acc, never strobe.
                  busyQ <= 1'b0;
                  state <= MUL_IDLE;
`ifdef SR_MUL_EARLY_EXIT_EN
               end else if (mplier == '0) begin
                  // No multiplier bits left, so acc is already the final product.
                  endMul <= 1'b1;
                  state  <= MUL_DONE;
`endif
               end else begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;   // carry out is dropped on purpose
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
                  // Last iteration when the incremented count reaches W.
                  if (cnt == CNT_W'(W - 1)) begin
                     endMul <= 1'b1;
                     state  <= MUL_DONE;
                  end
               end
            end

            MUL_DONE: begin
               // start is still high here with stale operands: never recapture.
               endMul <= 1'b0;
               busyQ  <= 1'b0;
               state  <= MUL_IDLE;
            end

            default: begin
               endMul <= 1'b0;
               busyQ  <= 1'b0;
               state  <= MUL_IDLE;
            end
         endcase
      end
   end

   assign mulIf.res_mul = acc;
   assign mulIf.end_mul = endMul;
   assign mulIf.busy    = busyQ;

endmodule

// File: tb/tb_sr_seq_mul.sv
// Purpose : directed self-checking bench for sr_seq_mul (results, latency, strobe width, abort, reset).
// Latency : expected latency follows the build (SR_MUL_EARLY_EXIT_EN or fixed W+1).
// Backpressure: bench plays the CPU, holding start until end_mul.
module tb_sr_seq_mul;
   import sr_mul_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   nChecks = 0;
   int   nErrors = 0;

   sr_seq_mul_if #(.W(MUL_W)) mulIf ();

   sr_seq_mul #(.W(MUL_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .mulIf (mulIf.slave)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Cycles from the start sample (capture edge counted as 1) to the end_mul cycle.
   function automatic int expLat(input logic [31:0] bv);
`ifdef SR_MUL_EARLY_EXIT_EN
      int msb = -1;
      for (int i = 0; i < 32; i++) if (bv[i]) msb = i;
      return (msb + 3 > MUL_W + 1) ? MUL_W + 1 : msb + 3;
`else
      return MUL_W + 1;
`endif
   endfunction

   // One full MUL from the CPU side. Called #1 after an edge. Operands are
   // scrambled after the capture edge to prove they are not re-read.
   task automatic runMul(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] expRes, input bit hold);
      int lat = 0;
      bit seen = 0;
      mulIf.a     = av;
      mulIf.b     = bv;
      mulIf.start = 1'b1;
      while (!seen && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            mulIf.a = ~av;
            mulIf.b = bv ^ 32'h5A5A_A5A5;
         end
         if (mulIf.end_mul) seen = 1;
      end
      checkVal({tag, "_seen"}, 64'(seen), 64'd1);
      checkVal({tag, "_lat"}, 64'(lat), 64'(expLat(bv)));
      checkVal({tag, "_res"}, 64'(mulIf.res_mul), 64'(expRes));
      checkVal({tag, "_busyDone"}, 64'(mulIf.busy), 64'd1);
      @(posedge clk); #1;
      checkVal({tag, "_strobe1"}, 64'(mulIf.end_mul), 64'd0);
      checkVal({tag, "_idle"}, 64'(mulIf.busy), 64'd0);
      checkVal({tag, "_hold"}, 64'(mulIf.res_mul), 64'(expRes));
      if (!hold) begin
         mulIf.start = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int strobes;
      rst         = 1'b1;
      mulIf.start = 1'b0;
      mulIf.a     = '0;
      mulIf.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_end", 64'(mulIf.end_mul), 64'd0);
      checkVal("rst_busy", 64'(mulIf.busy), 64'd0);
      checkVal("rst_res", 64'(mulIf.res_mul), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      runMul("m7x6", 32'd7, 32'd6, 32'd42, 0);
      runMul("mFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      runMul("m8x2", 32'h8000_0000, 32'd2, 32'h0000_0000, 0);

      // Back-to-back: start held across DONE, new operands the cycle after.
      runMul("b2b1", 32'd3, 32'd5, 32'd15, 1);
      runMul("b2b2", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);

      // Abort after 10 BUSY cycles.
      mulIf.a     = 32'h111;
      mulIf.b     = 32'h00FF_FFFF;
      mulIf.start = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      checkVal("abort_pre", 64'(mulIf.busy), 64'd1);
      mulIf.start = 1'b0;
      @(posedge clk); #1;
      checkVal("abort_idle", 64'(mulIf.busy), 64'd0);
      strobes = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (mulIf.end_mul) strobes++;
      end
      checkVal("abort_nostrobe", 64'(strobes), 64'd0);
      runMul("m9x9", 32'd9, 32'd9, 32'd81, 0);

      // Reset after 20 BUSY iterations (multiplier bits 0..19 consumed).
      mulIf.a     = 32'h0001_2345;
      mulIf.b     = 32'h00FF_FFFF;
      mulIf.start = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      checkVal("rstmid_busy", 64'(mulIf.busy), 64'd1);
      checkVal("rstmid_acc", 64'(mulIf.res_mul), 64'(32'(64'h1_2345 * 64'h0F_FFFF)));
      rst = 1'b1;
      @(posedge clk); #1;
      checkVal("rstmid_end", 64'(mulIf.end_mul), 64'd0);
      checkVal("rstmid_busy0", 64'(mulIf.busy), 64'd0);
      checkVal("rstmid_res", 64'(mulIf.res_mul), 64'd0);
      rst         = 1'b0;
      mulIf.start = 1'b0;
      @(posedge clk); #1;
      runMul("m4x4", 32'd4, 32'd4, 32'd16, 0);

      // Early-exit vectors (fixed latency in the default build).
      runMul("m123x0", 32'd123, 32'd0, 32'd0, 0);
      runMul("m123x1", 32'd123, 32'd1, 32'd123, 0);
      runMul("m5x80", 32'd5, 32'h8000_0000, 32'h8000_0000, 0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/sr_seq_mul.md
# sr_seq_mul

Sequential radix-2 shift-add multiplier that answers the CPU's `start`/`end_mul` multiply handshake. The CPU holds `start` high and its operands stable while a MUL instruction is stalled. The block returns the low 32 bits of the product (RISC-V `MUL` semantics) with a one-cycle `end_mul` strobe. It sits beside the ALU in the single-cycle core and is the responder end of the core's multiply interface.

## Interface
- `W`, default 32: operand and result width.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `a  in  W`: multiplicand. Sampled only on the capture edge.
- `b  in  W`: multiplier. Sampled only on the capture edge.
- `start  in  1`: level request. Held high by the initiator for the whole MUL instruction.
- `res_mul  out  W`: low W bits of `a*b`. Valid while `end_mul`=1. Holds the last result otherwise.
- `end_mul  out  1`: one-cycle completion strobe.
- `busy  out  1`: high in BUSY and DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Registers:
  - `mcand`: W bits, shifts left.
  - `mplier`: W bits, shifts right.
  - `acc`: W bits.
  - `cnt`: $clog2(W)+1 bits.
- IDLE:
  - If `start`=1 at a clock edge, that edge is the capture edge: `mcand`←a, `mplier`←b, `acc`←0, `cnt`←0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, at each edge:
  - If `mplier[0]`, then `acc`←`acc`+`mcand`, keeping the low W bits; carry is discarded.
  - `mcand`←`mcand`<<1, `mplier`←`mplier`>>1, `cnt`←`cnt`+1.
  - When the incremented `cnt` reaches W, go to DONE.
- DONE:
  - `end_mul`=1 and `res_mul`=`acc`.
  - The next edge always returns to IDLE, whatever `start` is. The initiator's `start` is still high on that edge with stale operands, so it must not be recaptured.
- Abort: `start`=0 sampled in BUSY → return to IDLE at that edge. `acc` is left as is and `end_mul` is never raised for that operation.
- Signedness: none needed. The low W bits are identical for signed and unsigned operands.
- `res_mul` is driven straight from `acc` with no extra output register.

## Timing
- Reset values: state IDLE, `end_mul`=0, `busy`=0, `res_mul`=0 (`acc` cleared), `cnt`=0.
- Reset wins over every other event, including mid-BUSY and in DONE.
- Latency: if the capture edge is edge 0, `end_mul` is high in the cycle after edge W. That is W+1 cycles after `start` is first seen in IDLE, so 33 cycles for W=32.
- Back-to-back MULs: the next capture happens no earlier than one cycle after DONE. The minimum issue interval is W+2 cycles.
- `end_mul` is never high for two consecutive cycles.
- `start` is ignored while in DONE.
- Operand changes on `a`/`b` after the capture edge have no effect.

## Configuration
- `SR_MUL_EARLY_EXIT_EN` defined:
  - In BUSY, if `mplier`==0 at an edge, go to DONE at that edge. The remaining iterations are skipped because `acc` is already final.
  - `b`=0 gives `end_mul` in the cycle after edge 1.
  - `b`=1 gives `end_mul` in the cycle after edge 2.
  - In general, latency is (index of highest set bit of `b`)+3 cycles from the `start` sample, capped at W+1.
- Undefined: fixed W+1 cycle latency for all operands. `cnt` is the only exit condition.
- `res_mul` values are identical in both builds.

## Structure
- Shared package `sr_mul_pkg`:
  - `typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t`.
  - `localparam MUL_W = 32`.
  - Count-width localparam derived from `MUL_W`.
- Single module, no sub-module. The datapath is three shift/add registers and a counter, and does not justify a split.

## Test plan
- 7 × 6 with `start` held until `end_mul` → `res_mul`=42. `end_mul` is high for exactly one cycle, 33 cycles after `start` is first sampled (fixed build).
- 0xFFFFFFFF × 0xFFFFFFFF → `res_mul`=0x00000001. 0x80000000 × 2 → 0x00000000 (overflow truncated).
- Back-to-back: 3×5 then 0x10000×0x10000. `start` stays high across the DONE cycle and the operands change the cycle after DONE.
  - Expect 15, then 0.
  - The second operation captures no earlier than the cycle after DONE, with no stale recapture.
- Abort: drop `start` at cycle 10 of BUSY → state IDLE next cycle. No `end_mul` appears within the following 40 cycles. A fresh 9×9 afterwards yields 81.
- Reset mid-operation: assert `rst` at BUSY cycle 20 → next cycle `end_mul`=0, `busy`=0, `res_mul`=0. A new 4×4 then yields 16 with full latency.
- With `SR_MUL_EARLY_EXIT_EN`:
  - 123×0 → `end_mul` 2 cycles after the `start` sample, `res_mul`=0.
  - 123×1 → 3 cycles, result 123.
  - 5×0x80000000 → 33 cycles, result 0x80000000.
